processor_sequencer: RTL and testbench

- Scripted stimulus driver that sits directly upstream of the 8-bit serial processor. It drives the processor's Din, F and R inputs and its active-low LoadA, LoadB and Execute buttons from a small internal program memory.
- After each Execute operation it captures the processor's Aval/Bval outputs.
- Used for on-board self-test and for bench regression without manual switch and button entry.

---
 rtl/processor_sequencer_if.sv | 15 +
 rtl/processor_sequencer.sv | 157 +++++++++++++++
 tb/tb_processor_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/processor_sequencer_if.sv
// Pin bundle between the sequencer and the 8-bit serial processor: operand and
// select lines, the three active-low buttons, and the register read-back.
interface processor_sequencer_if;
  logic [7:0] Din;
  logic [2:0] F;
  logic [1:0] R;
  logic       LoadA;
  logic       LoadB;
  logic       Execute;
  logic [7:0] Aval;
  logic [7:0] Bval;

  modport master (output Din, F, R, LoadA, LoadB, Execute, input Aval, Bval);
  modport slave  (input Din, F, R, LoadA, LoadB, Execute, output Aval, Bval);
endinterface

// File: rtl/processor_sequencer.sv
// Scripted button/switch driver for the 8-bit serial processor: plays a small
// program of LDA/LDB/EXEC/HALT words and captures Aval/Bval after each EXEC.
module processor_sequencer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int SETUP_LEN = 4,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  prog_we,
  input  logic [AW-1:0]         prog_addr,
  input  logic [15:0]           prog_data,
  processor_sequencer_if.master proc,
  output logic                  Busy,
  output logic                  Done,
  output logic [AW-1:0]         PC,
  output logic [7:0]            ResA,
  output logic [7:0]            ResB,
  output logic                  ResValid
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_PRESS   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [1:0] OP_LDA  = 2'b00;
  localparam logic [1:0] OP_LDB  = 2'b01;
  localparam logic [1:0] OP_EXEC = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam int MAX_SP  = (SETUP_LEN > PULSE_LEN) ? SETUP_LEN : PULSE_LEN;
  localparam int MAX_LEN = (MAX_SP > GAP_LEN) ? MAX_SP : GAP_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);

  logic [15:0]   mem [DEPTH];
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic [15:0]   word;
  logic          idle_or_done;
  logic          reserved_unused;

  assign word            = mem[PC];
  assign idle_or_done    = (state == S_IDLE) || (state == S_DONE);
  assign reserved_unused = word[8];

  // NOTE: the program store has no reset so it maps onto plain RAM; its contents
  // survive Reset, and writes are only accepted while no program is running.
  always_ff @(posedge Clk) begin
    if (prog_we && idle_or_done) mem[prog_addr] <= prog_data;
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      op_q         <= OP_LDA;
      proc.Din     <= '0;
      proc.F       <= '0;
      proc.R       <= '0;
      proc.LoadA   <= 1'b1;
      proc.LoadB   <= 1'b1;
      proc.Execute <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      PC           <= '0;
      ResA         <= '0;
      ResB         <= '0;
      ResValid     <= 1'b0;
    end else begin
      ResValid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            PC    <= '0;
            Done  <= 1'b0;
            Busy  <= 1'b1;
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (word[15:14] == OP_HALT) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end else begin
            // EXEC reuses whatever operand the processor last saw on Din.
            if (word[15:14] != OP_EXEC) proc.Din <= word[7:0];
            proc.F <= word[13:11];
            proc.R <= word[10:9];
            op_q   <= word[15:14];
            cnt    <= CW'(SETUP_LEN - 1);
            state  <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (cnt == '0) begin
            proc.LoadA   <= (op_q != OP_LDA);
            proc.LoadB   <= (op_q != OP_LDB);
            proc.Execute <= (op_q != OP_EXEC);
            cnt          <= CW'(PULSE_LEN - 1);
            state        <= S_PRESS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_PRESS: begin
          if (cnt == '0) begin
            proc.LoadA   <= 1'b1;
            proc.LoadB   <= 1'b1;
            proc.Execute <= 1'b1;
            cnt          <= CW'(GAP_LEN - 1);
            state        <= S_RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_RELEASE: begin
          if (cnt == '0) begin
            // The gap is long enough for the processor's shift to settle, so
            // its registers are read on the last gap cycle.
            if (op_q == OP_EXEC) begin
              ResA     <= proc.Aval;
              ResB     <= proc.Bval;
              ResValid <= 1'b1;
            end
            if (PC == AW'(DEPTH - 1)) begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= S_DONE;
            end else begin
              PC    <= PC + AW'(1);
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_processor_sequencer.sv
// Self-checking bench for processor_sequencer: a timeline model derived from
// instruction timing, a simple processor stub, directed and random programs.
module tb_processor_sequencer;

  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int SETUP_LEN = 4;
  localparam int PULSE_LEN = 4;
  localparam int GAP_LEN   = 16;
  localparam int INSTR_LEN = 1 + SETUP_LEN + PULSE_LEN + GAP_LEN;

  logic          Clk;
  logic          Reset;
  logic          Start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          Busy, Done, ResValid;
  logic [AW-1:0] PC;
  logic [7:0]    ResA, ResB;

  processor_sequencer_if pif ();

  processor_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .SETUP_LEN(SETUP_LEN), .PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .proc(pif), .Busy(Busy), .Done(Done), .PC(PC),
    .ResA(ResA), .ResB(ResB), .ResValid(ResValid)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Processor stub: load-only registers, or random noise to probe capture timing.
  logic noisy = 1'b0;
  initial begin
    pif.Aval = 8'h00;
    pif.Bval = 8'h00;
  end
  always @(negedge Clk) begin
    if (noisy) begin
      pif.Aval = 8'($urandom);
      pif.Bval = 8'($urandom);
    end else begin
      if (!pif.LoadA) pif.Aval = pif.Din;
      if (!pif.LoadB) pif.Bval = pif.Din;
    end
  end

  // Reference model: outputs derived from elapsed cycles since the accepted Start.
  logic [15:0]   prog_model [DEPTH];
  logic          m_busy = 1'b0, m_done = 1'b0, m_resv = 1'b0;
  logic [AW-1:0] m_pc = '0;
  logic [7:0]    m_din = '0, m_resa = '0, m_resb = '0;
  logic [2:0]    m_f = '0;
  logic [1:0]    m_r = '0;
  logic [2:0]    m_btn = 3'b111;   // {Execute, LoadB, LoadA}
  int            k = 0;

  always @(posedge Clk or negedge Reset) begin
    int idx, ph;
    logic [15:0] w;
    if (!Reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_pc = '0; m_din = '0; m_f = '0; m_r = '0;
      m_btn = 3'b111; m_resa = '0; m_resb = '0; m_resv = 1'b0;
    end else begin
      m_resv = 1'b0;
      if (!m_busy) begin
        if (prog_we) prog_model[prog_addr] = prog_data;
        if (Start) begin
          m_busy = 1'b1; m_done = 1'b0; m_pc = '0; k = 0;
        end
      end else begin
        k++;
        idx = k / INSTR_LEN;
        ph  = k % INSTR_LEN;
        if (ph == 0) begin
          if (prog_model[idx-1][15:14] == 2'b10) begin
            m_resa = pif.Aval; m_resb = pif.Bval; m_resv = 1'b1;
          end
          if (idx == DEPTH) begin
            m_busy = 1'b0; m_done = 1'b1;
          end else begin
            m_pc = AW'(idx);
          end
        end else if (ph == 1) begin
          w = prog_model[idx];
          if (w[15:14] == 2'b11) begin
            m_busy = 1'b0; m_done = 1'b1;
          end else begin
            if (w[15:14] != 2'b10) m_din = w[7:0];
            m_f = w[13:11];
            m_r = w[10:9];
          end
        end
      end
      m_btn = 3'b111;
      if (m_busy) begin
        idx = k / INSTR_LEN;
        ph  = k % INSTR_LEN;
        if (ph >= 1 + SETUP_LEN && ph < 1 + SETUP_LEN + PULSE_LEN)
          m_btn[prog_model[idx][15:14]] = 1'b0;
      end
    end
  end

  // Per-cycle compare plus button-safety scoreboard.
  int   la_cnt = 0, lb_cnt = 0, ex_cnt = 0, rv_cnt = 0;
  logic [2:0] prev_btn = 3'b111;
  logic [7:0] prev_din = '0;
  logic [2:0] prev_f = '0;
  logic [1:0] prev_r = '0;

  always @(negedge Clk) begin
    logic [2:0] btn;
    btn = {pif.Execute, pif.LoadB, pif.LoadA};
    check("Busy", 32'(Busy), 32'(m_busy));
    check("Done", 32'(Done), 32'(m_done));
    check("PC", 32'(PC), 32'(m_pc));
    check("Din", 32'(pif.Din), 32'(m_din));
    check("F", 32'(pif.F), 32'(m_f));
    check("R", 32'(pif.R), 32'(m_r));
    check("buttons", 32'(btn), 32'(m_btn));
    check("ResA", 32'(ResA), 32'(m_resa));
    check("ResB", 32'(ResB), 32'(m_resb));
    check("ResValid", 32'(ResValid), 32'(m_resv));
    check("one_button_low", 32'($countones(~btn) <= 1), 32'(1));
    if (btn != 3'b111 && prev_btn != 3'b111) begin
      check("din_hold_while_pressed", 32'(pif.Din), 32'(prev_din));
      check("f_hold_while_pressed", 32'(pif.F), 32'(prev_f));
      check("r_hold_while_pressed", 32'(pif.R), 32'(prev_r));
    end
    if (prev_btn[0] && !btn[0]) la_cnt++;
    if (prev_btn[1] && !btn[1]) lb_cnt++;
    if (prev_btn[2] && !btn[2]) ex_cnt++;
    if (ResValid) rv_cnt++;
    prev_btn = btn;
    prev_din = pif.Din;
    prev_f   = pif.F;
    prev_r   = pif.R;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge Clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    while (n < budget) begin
      if (Done) break;
      if (rnd) begin
        Start     = ($urandom_range(0, 7) == 0);
        prog_we   = ($urandom_range(0, 3) == 0);
        prog_addr = AW'($urandom);
        prog_data = 16'($urandom);
      end
      @(negedge Clk);
      n++;
    end
    Start = 1'b0; prog_we = 1'b0;
    check("done_within_budget", 32'(Done), 32'(1));
  endtask

  initial begin
    int la0, lb0, ex0, rv0, la_first, lb_first, la_low, lb_low, n;
    logic [1:0] op;
    Start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    Reset = 1'b0;
    tick(3);
    check("rst_LoadA", 32'(pif.LoadA), 32'(1));
    check("rst_Execute", 32'(pif.Execute), 32'(1));
    check("rst_Busy", 32'(Busy), 32'(0));
    check("rst_PC", 32'(PC), 32'(0));
    Reset = 1'b1;
    tick(2);

    // LDA 0x33, LDB 0x55, HALT: press windows at fixed cycles after Start.
    write_word(0, 16'h0033);
    write_word(1, 16'h4055);
    write_word(2, 16'hC000);
    pulse_start();
    la_first = -1; lb_first = -1; la_low = 0; lb_low = 0;
    for (int p = 0; p < 60; p++) begin
      if (p >= 1 && p <= 4) check("lda_setup_din", 32'(pif.Din), 32'h33);
      if (!pif.LoadA) begin
        if (la_first < 0) la_first = p + 1;
        la_low++;
        check("lda_press_din", 32'(pif.Din), 32'h33);
      end
      if (!pif.LoadB) begin
        if (lb_first < 0) lb_first = p + 1;
        lb_low++;
        check("ldb_press_din", 32'(pif.Din), 32'h55);
      end
      @(negedge Clk);
    end
    check("lda_first_cycle", 32'(la_first), 32'(6));
    check("lda_low_cycles", 32'(la_low), 32'(4));
    check("ldb_first_cycle", 32'(lb_first), 32'(31));
    check("ldb_low_cycles", 32'(lb_low), 32'(4));
    check("halt_done", 32'(Done), 32'(1));
    check("halt_busy", 32'(Busy), 32'(0));
    check("halt_pc", 32'(PC), 32'(2));

    // LDA 0x0F, LDB 0xF0, EXEC F=000 R=00, HALT: one capture of the loaded registers.
    write_word(0, 16'h000F);
    write_word(1, 16'h40F0);
    write_word(2, 16'h8000);
    write_word(3, 16'hC000);
    rv0 = rv_cnt;
    pulse_start();
    wait_done(200, 1'b0);
    check("exec_resvalid_pulses", 32'(rv_cnt - rv0), 32'(1));
    check("exec_ResA", 32'(ResA), 32'h0F);
    check("exec_ResB", 32'(ResB), 32'hF0);

    // All sixteen words LDA, no HALT: ends at PC 15 with exactly 16 presses.
    for (int i = 0; i < DEPTH; i++) write_word(AW'(i), {8'h00, 8'(i * 17)});
    la0 = la_cnt;
    pulse_start();
    wait_done(DEPTH * INSTR_LEN + 20, 1'b0);
    check("full_pc", 32'(PC), 32'(15));
    check("full_presses", 32'(la_cnt - la0), 32'(16));
    tick(30);
    check("full_pc_after", 32'(PC), 32'(15));
    check("full_no_extra_press", 32'(la_cnt - la0), 32'(16));

    // Start and prog_we during a run are ignored; the same write lands once idle.
    write_word(0, 16'h00A5);
    write_word(1, 16'h405A);
    write_word(2, 16'hC000);
    la0 = la_cnt; lb0 = lb_cnt;
    pulse_start();
    tick(3);
    Start = 1'b1; prog_we = 1'b1; prog_addr = 0; prog_data = 16'hC000;
    tick(3);
    Start = 1'b0; prog_we = 1'b0;
    wait_done(200, 1'b0);
    check("busy_write_lda", 32'(la_cnt - la0), 32'(1));
    check("busy_write_ldb", 32'(lb_cnt - lb0), 32'(1));
    check("busy_write_pc", 32'(PC), 32'(2));
    la0 = la_cnt;
    pulse_start();
    wait_done(200, 1'b0);
    check("mem0_kept", 32'(la_cnt - la0), 32'(1));
    write_word(0, 16'hC000);
    la0 = la_cnt; lb0 = lb_cnt; ex0 = ex_cnt;
    pulse_start();
    tick(3);
    check("halt_now_done", 32'(Done), 32'(1));
    check("halt_now_pc", 32'(PC), 32'(0));
    check("halt_now_no_press", 32'((la_cnt - la0) + (lb_cnt - lb0) + (ex_cnt - ex0)), 32'(0));

    // Asynchronous reset in the middle of an EXEC press.
    write_word(0, 16'h0011);
    write_word(1, 16'h9B77);
    write_word(2, 16'hC000);
    pulse_start();
    n = 0;
    while (pif.Execute && n < 80) begin
      @(negedge Clk);
      n++;
    end
    check("exec_press_seen", 32'(pif.Execute), 32'(0));
    #2 Reset = 1'b0;
    #1;
    check("async_Execute", 32'(pif.Execute), 32'(1));
    check("async_Busy", 32'(Busy), 32'(0));
    check("async_PC", 32'(PC), 32'(0));
    @(negedge Clk);
    Reset = 1'b1;
    tick(2);
    pulse_start();
    n = 0;
    while (pif.LoadA && pif.LoadB && pif.Execute && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("restart_LoadA", 32'(pif.LoadA), 32'(0));
    check("restart_Din", 32'(pif.Din), 32'h11);
    check("restart_PC", 32'(PC), 32'(0));
    wait_done(200, 1'b0);

    // Random programs with noisy processor registers and random Start/prog_we.
    for (int it = 0; it < 4; it++) begin
      noisy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        op = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        write_word(AW'(i), {op, 14'($urandom)});
      end
      noisy = 1'b1;
      pulse_start();
      wait_done(DEPTH * INSTR_LEN + 20, 1'b1);
      tick(3);
    end
    noisy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
